// File: rtl/line_sensor_adc.sv
// Scans three IR reflectance channels on a serial ADC and thresholds each with hysteresis.
// Latency: one scan of 4 frames takes 129*CLK_DIV cycles from cs_n fall to sensor_valid.
// Backpressure: none; results are published as a one-cycle strobe and then held.
//
// Ports:
//   clk, reset         system clock; asynchronous active-high reset
//   enable             scanning permitted (a started scan always completes)
//   adc_cs_n, adc_sck  ADC chip select (active low) and serial clock (idles high)
//   adc_din, adc_dout  control bits to the ADC / conversion data from the ADC
//   line_sensor        {left, centre, right}, 1 = black (hysteresis state bits)
//   raw_l/raw_c/raw_r  last 12-bit conversion per channel
//   sensor_valid       one-cycle pulse when the outputs above update
module line_sensor_adc #(
    parameter int         CLK_DIV  = 20,     // SCLK half-period in clk cycles (>=2)
    parameter int         SCAN_GAP = 1000,   // cycles with cs_n high between scans (1..65536)
    parameter logic [2:0] CH_L     = 3'd0,
    parameter logic [2:0] CH_C     = 3'd1,
    parameter logic [2:0] CH_R     = 3'd2,
    parameter logic [11:0] THRESH  = 12'd2048,
    parameter logic [11:0] HYST    = 12'd64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic        adc_cs_n,
    output logic        adc_sck,
    output logic        adc_din,
    input  logic        adc_dout,
    output logic [2:0]  line_sensor,
    output logic [11:0] raw_l,
    output logic [11:0] raw_c,
    output logic [11:0] raw_r,
    output logic        sensor_valid
);

    typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, GAP} state_t;

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0] GAP_LAST = 16'(SCAN_GAP - 1);

    // Hysteresis levels computed 13 bits wide, then clamped to the 12-bit range.
    localparam logic [12:0] HI_SUM = {1'b0, THRESH} + {1'b0, HYST};
    localparam logic [12:0] LO_DIF = {1'b0, THRESH} - {1'b0, HYST};
    localparam logic [11:0] HI_LVL = HI_SUM[12] ? 12'hFFF : HI_SUM[11:0];
    localparam logic [11:0] LO_LVL = LO_DIF[12] ? 12'h000 : LO_DIF[11:0];

    state_t      state, state_nxt;
    logic [15:0] cnt;          // clock divider in CS_SETUP/SHIFT/CS_HOLD, gap counter in GAP
    logic [5:0]  bit_cnt;      // SCLK period within the scan: {frame[1:0], bit[3:0]}
    logic [10:0] shreg;
    logic [11:0] cap_l, cap_c, cap_r;
    logic        tick, gap_done, ctrl_bit;
    logic [2:0]  frame_addr;
    logic [7:0]  ctrl_word;
    logic [11:0] sample;

    assign tick     = (cnt == DIV_LAST);
    assign gap_done = (cnt == GAP_LAST);
    assign sample   = {shreg, adc_dout};

    function automatic logic hyst_next(input logic b, input logic [11:0] raw);
        if (!b) return (raw >= HI_LVL);
        return !(raw < LO_LVL);
    endfunction

    // Address sent in frame n selects the conversion returned in frame n+1.
    always_comb begin
        frame_addr = CH_L;
        case (bit_cnt[5:4])
            2'd0:    frame_addr = CH_L;
            2'd1:    frame_addr = CH_C;
            2'd2:    frame_addr = CH_R;
            default: frame_addr = CH_L;
        endcase
        ctrl_word = {2'b00, frame_addr, 3'b000};
        // Control word goes out MSB first on bits 0..7; bits 8..15 are zero.
        ctrl_bit  = bit_cnt[3] ? 1'b0 : ctrl_word[~bit_cnt[2:0]];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (enable) state_nxt = CS_SETUP;
            CS_SETUP: if (tick) state_nxt = SHIFT;
            // sck low at a tick means this tick is a rising edge.
            SHIFT:    if (tick && !adc_sck && bit_cnt == 6'd63) state_nxt = CS_HOLD;
            CS_HOLD:  if (tick) state_nxt = GAP;
            GAP:      if (gap_done) state_nxt = enable ? CS_SETUP : IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt          <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            cap_l        <= '0;
            cap_c        <= '0;
            cap_r        <= '0;
            adc_cs_n     <= 1'b1;
            adc_sck      <= 1'b1;
            adc_din      <= 1'b0;
            line_sensor  <= 3'b000;
            raw_l        <= '0;
            raw_c        <= '0;
            raw_r        <= '0;
            sensor_valid <= 1'b0;
        end else begin
            sensor_valid <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (enable) begin
                        adc_cs_n <= 1'b0;
                        bit_cnt  <= '0;
                    end
                end
                CS_SETUP: begin
                    cnt <= tick ? 16'd0 : cnt + 16'd1;
                    if (tick) begin
                        adc_sck <= 1'b0;
                        adc_din <= ctrl_bit;
                    end
                end
                SHIFT: begin
                    cnt <= tick ? 16'd0 : cnt + 16'd1;
                    if (tick) begin
                        if (adc_sck) begin
                            adc_sck <= 1'b0;
                            adc_din <= ctrl_bit;
                        end else begin
                            adc_sck <= 1'b1;
                            bit_cnt <= bit_cnt + 6'd1;
                            // Bits 4..15 carry the result MSB first.
                            if (bit_cnt[3:0] >= 4'd4) shreg <= sample[10:0];
                            if (bit_cnt[3:0] == 4'd15) begin
                                case (bit_cnt[5:4])
                                    2'd1:    cap_l <= sample;
                                    2'd2:    cap_c <= sample;
                                    2'd3:    cap_r <= sample;
                                    default: ;  // frame 0 data is stale
                                endcase
                            end
                        end
                    end
                end
                CS_HOLD: begin
                    cnt <= tick ? 16'd0 : cnt + 16'd1;
                    if (tick) begin
                        adc_cs_n     <= 1'b1;
                        raw_l        <= cap_l;
                        raw_c        <= cap_c;
                        raw_r        <= cap_r;
                        line_sensor  <= {hyst_next(line_sensor[2], cap_l),
                                         hyst_next(line_sensor[1], cap_c),
                                         hyst_next(line_sensor[0], cap_r)};
                        sensor_valid <= 1'b1;
                    end
                end
                GAP: begin
                    cnt <= cnt + 16'd1;
                    if (gap_done) begin
                        cnt <= '0;
                        if (enable) begin
                            adc_cs_n <= 1'b0;
                            bit_cnt  <= '0;
                        end
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_line_sensor_adc.sv
module tb_line_sensor_adc;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    logic enable2 = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Instance A: default parameters. B/C: fast scan, saturating thresholds; they share stimulus.
    logic        cs_a, sck_a, din_a, v_a;
    logic [2:0]  line_a;
    logic [11:0] rl_a, rc_a, rr_a;
    logic        cs_b, sck_b, din_b, v_b;
    logic [2:0]  line_b;
    logic [11:0] rl_b, rc_b, rr_b;
    logic        cs_c, sck_c, din_c, v_c;
    logic [2:0]  line_c;
    logic [11:0] rl_c, rc_c, rr_c;
    logic [1:0]  dout_m = 2'b00;

    line_sensor_adc dut_a (
        .clk(clk), .reset(reset), .enable(enable),
        .adc_cs_n(cs_a), .adc_sck(sck_a), .adc_din(din_a), .adc_dout(dout_m[0]),
        .line_sensor(line_a), .raw_l(rl_a), .raw_c(rc_a), .raw_r(rr_a), .sensor_valid(v_a));

    line_sensor_adc #(.CLK_DIV(2), .SCAN_GAP(1), .THRESH(12'hFF0), .HYST(12'h040)) dut_b (
        .clk(clk), .reset(reset), .enable(enable2),
        .adc_cs_n(cs_b), .adc_sck(sck_b), .adc_din(din_b), .adc_dout(dout_m[1]),
        .line_sensor(line_b), .raw_l(rl_b), .raw_c(rc_b), .raw_r(rr_b), .sensor_valid(v_b));

    line_sensor_adc #(.CLK_DIV(2), .SCAN_GAP(1), .THRESH(12'h020), .HYST(12'h040)) dut_c (
        .clk(clk), .reset(reset), .enable(enable2),
        .adc_cs_n(cs_c), .adc_sck(sck_c), .adc_din(din_c), .adc_dout(dout_m[1]),
        .line_sensor(line_c), .raw_l(rl_c), .raw_c(rc_c), .raw_r(rr_c), .sensor_valid(v_c));

    // ADC models (index 0 follows dut_a, index 1 follows dut_b), evaluated on the falling clk edge.
    logic [11:0] val [2][8];
    logic [2:0]  addr [2][4];
    logic [7:0]  ctrl [2];
    logic        prev_cs [2] = '{1'b1, 1'b1};
    logic        prev_sck [2] = '{1'b1, 1'b1};
    int          nb [2] = '{0, 0};
    int          nfalls [2] = '{0, 0};
    int          fall_cyc [2] = '{0, 0};
    int          prev_fall_cyc [2] = '{0, 0};
    int          nsck_scan [2] = '{0, 0};
    int          nsck_tot [2] = '{0, 0};
    int          nvalid [2] = '{0, 0};
    logic [11:0] junk = 12'hA5C;

    always @(negedge clk) begin
        logic cs_s [2];
        logic sck_s [2];
        logic din_s [2];
        logic vld_s [2];
        int k, f;
        cs_s[0] = cs_a;  sck_s[0] = sck_a;  din_s[0] = din_a;  vld_s[0] = v_a;
        cs_s[1] = cs_b;  sck_s[1] = sck_b;  din_s[1] = din_b;  vld_s[1] = v_b;
        for (int i = 0; i < 2; i++) begin
            if (prev_cs[i] && !cs_s[i]) begin
                nb[i] = 0;
                ctrl[i] = 8'h00;
                prev_fall_cyc[i] = fall_cyc[i];
                fall_cyc[i] = cyc;
                nfalls[i]++;
                nsck_scan[i] = 0;
            end
            k = nb[i] % 16;
            f = nb[i] / 16;
            if (prev_sck[i] && !sck_s[i]) begin
                nsck_tot[i]++;
                if (!cs_s[i]) begin
                    nsck_scan[i]++;
                    if (k < 4 || f > 3) dout_m[i] = 1'b0;
                    else if (f == 0)    dout_m[i] = junk[15-k];
                    else                dout_m[i] = val[i][addr[i][f-1]][15-k];
                end
            end
            if (!prev_sck[i] && sck_s[i] && !cs_s[i]) begin
                if (k < 8) ctrl[i] = {ctrl[i][6:0], din_s[i]};
                if (k == 7 && f < 4) addr[i][f] = ctrl[i][5:3];
                nb[i]++;
            end
            prev_cs[i] = cs_s[i];
            prev_sck[i] = sck_s[i];
            if (vld_s[i]) nvalid[i]++;
        end
    end

    typedef struct {
        logic [2:0]  line;
        logic [11:0] l, c, r;
    } exp_a_t;
    typedef struct {
        logic [2:0]  lb, lc;
        logic [11:0] raw;
    } exp_bc_t;
    exp_a_t  qa [$];
    exp_bc_t qbc [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input int idx, input int maxc, output bit ok, output int vc);
        ok = 1'b0;
        vc = 0;
        for (int n = 0; n < maxc && !ok; n++) begin
            @(negedge clk);
            if ((idx == 0) ? v_a : v_b) begin
                ok = 1'b1;
                vc = cyc;
            end
        end
    endtask

    task automatic check_scan_a(input string tag, output int vc);
        bit ok;
        exp_a_t e;
        wait_valid(0, 6000, ok, vc);
        chk({tag, "_valid_seen"}, 64'(ok), 64'd1);
        if (qa.size() > 0) begin
            e = qa.pop_front();
            if (ok) begin
                chk({tag, "_line"}, 64'(line_a), 64'(e.line));
                chk({tag, "_raw_l"}, 64'(rl_a), 64'(e.l));
                chk({tag, "_raw_c"}, 64'(rc_a), 64'(e.c));
                chk({tag, "_raw_r"}, 64'(rr_a), 64'(e.r));
            end
        end
    endtask

    task automatic check_scan_bc(input string tag, output int vc);
        bit ok;
        exp_bc_t e;
        wait_valid(1, 1000, ok, vc);
        chk({tag, "_valid_seen"}, 64'(ok), 64'd1);
        if (qbc.size() > 0) begin
            e = qbc.pop_front();
            if (ok) begin
                chk({tag, "_c_valid"}, 64'(v_c), 64'd1);
                chk({tag, "_line_b"}, 64'(line_b), 64'(e.lb));
                chk({tag, "_line_c"}, 64'(line_c), 64'(e.lc));
                chk({tag, "_raw_b"}, 64'({rl_b, rc_b, rr_b}), 64'({e.raw, e.raw, e.raw}));
                chk({tag, "_raw_c"}, 64'({rl_c, rc_c, rr_c}), 64'({e.raw, e.raw, e.raw}));
                chk({tag, "_c_pins"}, 64'({cs_c, sck_c, din_c}), 64'({cs_b, sck_b, din_b}));
            end
        end
    endtask

    task automatic wait_cs_fall(input int idx, input int maxc);
        int nf;
        bit seen;
        nf = nfalls[idx];
        seen = 1'b0;
        for (int n = 0; n < maxc && !seen; n++) begin
            @(negedge clk);
            if (nfalls[idx] != nf) seen = 1'b1;
        end
        chk("cs_fall_seen", 64'(seen), 64'd1);
    endtask

    initial begin
        int t_en, vc, nv, ns, nf;
        logic [11:0] c_seq [4];
        logic [2:0]  l_seq [4];
        c_seq = '{12'h7F0, 12'h840, 12'h7D0, 12'h7B0};
        l_seq = '{3'b000, 3'b010, 3'b010, 3'b000};
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 8; j++) val[i][j] = 12'h000;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_cs_n", 64'(cs_a), 64'd1);
        chk("rst_sck", 64'(sck_a), 64'd1);
        chk("rst_din", 64'(din_a), 64'd0);
        chk("rst_line", 64'(line_a), 64'd0);
        chk("rst_raw", 64'({rl_a, rc_a, rr_a}), 64'd0);
        chk("rst_valid", 64'(v_a), 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single scan with defaults
        val[0][0] = 12'h100; val[0][1] = 12'hC00; val[0][2] = 12'h100;
        qa.push_back('{3'b010, 12'h100, 12'hC00, 12'h100});
        enable = 1'b1;
        t_en = cyc;
        check_scan_a("single", vc);
        chk("first_edge_cs_fall", 64'(fall_cyc[0] - t_en), 64'd1);
        chk("scan_length", 64'(vc - fall_cyc[0]), 64'd2580);
        chk("sck_falls_per_scan", 64'(nsck_scan[0]), 64'd64);
        chk("din_addresses", 64'({addr[0][0], addr[0][1], addr[0][2], addr[0][3]}),
            64'(12'b000_001_010_000));
        chk("cs_high_at_valid", 64'(cs_a), 64'd1);

        // Asynchronous reset in the middle of the next scan's SHIFT phase
        wait_cs_fall(0, 2000);
        repeat (600) @(negedge clk);
        chk("mid_scan_cs_low", 64'(cs_a), 64'd0);
        reset = 1'b1;
        enable = 1'b0;
        #1;
        chk("arst_cs_n", 64'(cs_a), 64'd1);
        chk("arst_sck", 64'(sck_a), 64'd1);
        chk("arst_din", 64'(din_a), 64'd0);
        chk("arst_line", 64'(line_a), 64'd0);
        chk("arst_raw", 64'({rl_a, rc_a, rr_a}), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        nv = nvalid[0];
        ns = nsck_tot[0];
        repeat (7160) @(negedge clk);
        chk("no_valid_after_reset", 64'(nvalid[0] - nv), 64'd0);
        chk("no_sck_after_reset", 64'(nsck_tot[0] - ns), 64'd0);

        // Hysteresis on the centre channel; the last scan also drops enable mid-scan
        val[0][0] = 12'h100; val[0][2] = 12'h100;
        for (int s = 0; s < 4; s++) begin
            val[0][1] = c_seq[s];
            qa.push_back('{l_seq[s], 12'h100, c_seq[s], 12'h100});
            if (s == 0) enable = 1'b1;
            if (s == 3) begin
                wait_cs_fall(0, 2000);
                repeat (1440) @(negedge clk);
                chk("drop_in_frame2", 64'(nb[0] / 16), 64'd2);
                enable = 1'b0;
            end
            check_scan_a($sformatf("hyst%0d", s), vc);
            if (s >= 1) chk($sformatf("scan_period%0d", s), 64'(fall_cyc[0] - prev_fall_cyc[0]), 64'd3580);
        end
        ns = nsck_tot[0];
        nf = nfalls[0];
        repeat (4000) @(negedge clk);
        chk("idle_cs_high", 64'(cs_a), 64'd1);
        chk("idle_no_cs_fall", 64'(nfalls[0] - nf), 64'd0);
        chk("idle_no_sck", 64'(nsck_tot[0] - ns), 64'd0);

        // Saturated hysteresis bounds, fast scan period
        for (int j = 0; j < 8; j++) val[1][j] = 12'hFFE;
        qbc.push_back('{3'b000, 3'b111, 12'hFFE});
        enable2 = 1'b1;
        check_scan_bc("sat_ffe", vc);
        for (int j = 0; j < 8; j++) val[1][j] = 12'hFFF;
        qbc.push_back('{3'b111, 3'b111, 12'hFFF});
        check_scan_bc("sat_fff", vc);
        chk("fast_period", 64'(fall_cyc[1] - prev_fall_cyc[1]), 64'd259);
        for (int j = 0; j < 8; j++) val[1][j] = 12'h000;
        qbc.push_back('{3'b000, 3'b111, 12'h000});
        check_scan_bc("sat_000", vc);
        enable2 = 1'b0;
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/line_sensor_adc.md
# line_sensor_adc

Acquisition front-end that produces the 3-bit `line_sensor` word consumed by the line-following motor controller. It scans three IR reflectance channels on the on-board ADC128S022-style serial ADC and thresholds each reading with hysteresis. It publishes the raw 12-bit readings and the digitised line word with a one-cycle valid strobe. It sits between the ADC pins and the line-following FSM.

## Interface
- CLK_DIV, 20: SCLK half-period in clk cycles (≥2).
- SCAN_GAP, 1000: clk cycles with cs_n high between scans (≥1).
- CH_L, 3'd0: ADC channel address of the left sensor.
- CH_C, 3'd1: ADC channel address of the centre sensor.
- CH_R, 3'd2: ADC channel address of the right sensor.
- THRESH, 12'd2048: black/white decision level (raw ≥ level means black).
- HYST, 12'd64: hysteresis half-band.

Ports:
- clk  in  1  system clock. Reset is `reset`, asynchronous, active-high; clock is `clk`.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  scanning permitted.
- adc_cs_n  out  1  ADC chip select, active low.
- adc_sck  out  1  ADC serial clock, idles high.
- adc_din  out  1  control bits to the ADC.
- adc_dout  in  1  data from the ADC.
- line_sensor  out  3  {left, centre, right}; 1 = black.
- raw_l, raw_c, raw_r  out  12 each  last conversion per channel.
- sensor_valid  out  1  one-cycle pulse when outputs update.

## Operation
- States: IDLE, CS_SETUP, SHIFT, CS_HOLD, GAP.
- IDLE: cs_n=1, sck=1, din=0. If enable=1, the next edge enters CS_SETUP with cs_n=0.
- One scan is 4 back-to-back 16-bit frames with cs_n held low throughout.
  - The address sent in frame n selects the conversion returned in frame n+1.
  - Frame addresses are CH_L, CH_C, CH_R, CH_L.
  - Data from frame 0 is discarded. Frames 1, 2 and 3 return L, C and R respectively.
- Frame bit k=0..15 is one SCLK period: falling edge, then rising edge.
  - din changes on the same clk edge that drives sck low. It carries control word {2'b00, addr[2:0], 3'b000} on bits 0..7 and 0 on bits 8..15.
  - dout is sampled on the clk edge that drives sck high.
  - Bits 0..3 are ignored. Bits 4..15 are the result, MSB first.
- SHIFT runs 64 SCLK periods, counted by a 6-bit bit counter plus a clock-divider counter.
- CS_HOLD: sck stays high for CLK_DIV cycles. Then cs_n=1, outputs update, sensor_valid=1 for one cycle, and the block enters GAP.
- GAP: counts SCAN_GAP cycles, then goes to CS_SETUP if enable=1, else IDLE.
- enable low during a scan: the scan completes and publishes normally, then the block enters IDLE. A scan is never aborted by enable.
- Hysteresis, per channel, with state bit b:
  - If b=0: set b when raw ≥ THRESH+HYST.
  - If b=1: clear b when raw < THRESH−HYST.
  - Otherwise b holds.
  - Bounds are computed 13-bit: upper saturates at 4095, lower at 0.
  - line_sensor = {b_l, b_c, b_r}.
- Outputs hold their last values in IDLE/GAP and while enable=0.
- Reset (asynchronous, mid-scan included):
  - cs_n=1, sck=1, din=0, sensor_valid=0.
  - line_sensor=3'b000, raw_*=0, hysteresis bits=0, state=IDLE.
  - Partial scan data is discarded.

## Timing
- Let E0 be the clk edge where cs_n falls.
- sck falling edge of bit j (j=0..63): E0+(2j+1)·CLK_DIV. Rising edge: E0+(2j+2)·CLK_DIV.
- Last rising edge: E0+128·CLK_DIV.
- cs_n rises, raw_*/line_sensor update and sensor_valid=1, all at E0+129·CLK_DIV. The default scan is 2580 cycles.
- Next cs_n fall: E0+129·CLK_DIV+SCAN_GAP.
- From IDLE, cs_n falls on the first clk edge at which enable is sampled 1.
- All outputs are registered. Update is visible the cycle after the edge.

## Test plan
- Reset: assert reset mid-SHIFT → same cycle cs_n=1, sck=1, din=0, line_sensor=000, raw_*=0. No sensor_valid for 2·scan period after release with enable=0.
- Single scan (defaults): ADC model returns L=0x100, C=0xC00, R=0x100.
  - sensor_valid at E0+2580.
  - line_sensor=3'b010, raw_l=0x100, raw_c=0xC00, raw_r=0x100.
  - din addresses decode 0,1,2,0 across the 4 frames.
  - Exactly 64 sck falling edges per scan.
- Hysteresis: centre readings over consecutive scans 0x7F0, 0x840, 0x7D0, 0x7B0 → centre bit 0, 1, 1, 0.
- Enable drop: deassert enable during frame 2 → scan completes, valid pulses with correct data, then cs_n stays 1 and no further sck edges.
- Gap/restart: hold enable=1 → consecutive cs_n falls exactly 129·CLK_DIV+SCAN_GAP apart. With CLK_DIV=2, SCAN_GAP=1 the period is 259.
- Saturation: THRESH=0xFF0, HYST=0x40 → raw 0xFFE keeps bit 0, raw 0xFFF sets bit 1. THRESH=0x020, HYST=0x40 → bit clears only on… never below 0, and stays 1 for raw 0x000.
